// File: rtl/spi_xform_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_xform_slave_if
// Brief    : SPI pins plus receive-side status of the transform slave.
// Revision : 1.0
// ============================================================================
interface spi_xform_slave_if #(
    parameter int WIDTH = 8
);
    logic             sck;
    logic             ss;
    logic             mosi;
    logic             miso;
    logic [1:0]       op;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] frame_cnt;

    modport slave (
        input  sck, ss, mosi, op,
        output miso, rx_data, rx_valid, frame_cnt
    );

    modport master (
        output sck, ss, mosi, op,
        input  miso, rx_data, rx_valid, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/spi_xform_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_xform_slave
// Brief    : Synchronous SPI slave; receives a word, returns a transformed one.
// Revision : 1.0
// ============================================================================
module spi_xform_slave #(
    parameter int WIDTH       = 8,
    parameter bit SAMPLE_EDGE = 1'b0
) (
    input  wire logic           clock,
    input  wire logic           reset,
    spi_xform_slave_if.slave    bus
);
    localparam int         c_CW     = $clog2(WIDTH) + 1;
    localparam logic [0:0] c_ST_RX  = 1'b0;
    localparam logic [0:0] c_ST_TX  = 1'b1;
    localparam logic [1:0] c_OP_REV = 2'd0;
    localparam logic [1:0] c_OP_ECH = 2'd1;
    localparam logic [1:0] c_OP_INV = 2'd2;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    logic             r_sck_m, r_sck_s, r_sck_d;
    logic             r_ss_m, r_ss_s;
    logic             r_mosi_m, r_mosi_s;

    logic [0:0]       r_phase;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_rx_sr;
    logic [WIDTH-1:0] r_tx_sr;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic [WIDTH-1:0] r_frame_cnt;
    logic             r_miso;

    logic             w_edge;
    logic             w_last;
    logic [WIDTH-1:0] w_rx_word;
    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_result;

    // Synchronisers reset to the idle level so no edge is seen leaving reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sck_m  <= SAMPLE_EDGE;
            r_sck_s  <= SAMPLE_EDGE;
            r_sck_d  <= SAMPLE_EDGE;
            r_ss_m   <= 1'b1;
            r_ss_s   <= 1'b1;
            r_mosi_m <= 1'b0;
            r_mosi_s <= 1'b0;
        end else begin
            r_sck_m  <= bus.sck;
            r_sck_s  <= r_sck_m;
            r_sck_d  <= r_sck_s;
            r_ss_m   <= bus.ss;
            r_ss_s   <= r_ss_m;
            r_mosi_m <= bus.mosi;
            r_mosi_s <= r_mosi_m;
        end
    end

    assign w_edge    = (r_sck_s != r_sck_d) && (r_sck_s == SAMPLE_EDGE);
    assign w_last    = (r_cnt == c_LAST);
    assign w_rx_word = {r_rx_sr[WIDTH-2:0], r_mosi_s};

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rev[i] = w_rx_word[WIDTH-1-i];
        end
    end

    always_comb begin
        w_result = r_frame_cnt;
        case (bus.op)
            c_OP_REV: w_result = w_rev;
            c_OP_ECH: w_result = w_rx_word;
            c_OP_INV: w_result = ~w_rx_word;
            default:  w_result = r_frame_cnt;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase     <= c_ST_RX;
            r_cnt       <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_cnt <= '0;
            r_miso      <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            r_miso     <= (!r_ss_s && r_phase == c_ST_TX) ? r_tx_sr[WIDTH-1] : 1'b1;
            // ss high overrides any coincident edge and discards a partial word
            if (r_ss_s) begin
                r_phase <= c_ST_RX;
                r_cnt   <= '0;
            end else if (w_edge) begin
                if (r_phase == c_ST_RX) begin
                    r_rx_sr <= w_rx_word;
                    if (w_last) begin
                        r_rx_data   <= w_rx_word;
                        r_rx_valid  <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + WIDTH'(1);
                        r_tx_sr     <= w_result;
                        r_phase     <= c_ST_TX;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end else begin
                    r_tx_sr <= {r_tx_sr[WIDTH-2:0], 1'b0};
                    if (w_last) begin
                        r_phase <= c_ST_RX;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
            end
        end
    end

    assign bus.miso      = r_miso;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_cnt = r_frame_cnt;
endmodule
`default_nettype wire

// File: tb/tb_spi_xform_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xform_slave
// Brief    : Directed self-checking bench for spi_xform_slave (WIDTH=8, falling edge).
// Revision : 1.0
// ============================================================================
module tb_spi_xform_slave;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   vcount;
    int   v0;
    logic [7:0] r;
    logic       m;

    spi_xform_slave_if #(.WIDTH(8)) bus ();

    spi_xform_slave #(
        .WIDTH       (8),
        .SAMPLE_EDGE (1'b0)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) vcount++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sck period: miso sampled as sck rises, active falling edge mid-period
    task automatic xbit(input logic b, output logic mo);
        mo       = bus.miso;
        bus.mosi = b;
        bus.sck  = 1'b1;
        wait_n(6);
        bus.sck  = 1'b0;
        wait_n(6);
    endtask

    task automatic frame(input logic [1:0] o, input logic [7:0] w, output logic [7:0] rd);
        logic mo;
        bus.op = o;
        rd = '0;
        for (int i = 0; i < 16; i++) begin
            xbit((i < 8) ? w[7-i] : 1'b0, mo);
            if (i >= 8) rd[15-i] = mo;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        vcount   = 0;
        rst      = 1'b1;
        bus.ss   = 1'b1;
        bus.sck  = 1'b0;
        bus.mosi = 1'b0;
        bus.op   = 2'd0;
        wait_n(4);
        rst = 1'b0;
        wait_n(4);
        chk("reset_miso", 32'(bus.miso), 32'h1);
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
        chk("reset_rx_data", 32'(bus.rx_data), 32'h0);
        chk("reset_frame_cnt", 32'(bus.frame_cnt), 32'h0);

        // sck toggling with ss held high
        frame(2'd1, 8'h5A, r);
        chk("ss_high_miso", 32'(r), 32'hFF);
        chk("ss_high_valid_count", 32'(vcount), 32'h0);
        chk("ss_high_frame_cnt", 32'(bus.frame_cnt), 32'h0);

        // REV 0xB1
        bus.ss = 1'b0;
        wait_n(6);
        frame(2'd0, 8'hB1, r);
        wait_n(6);
        bus.ss = 1'b1;
        wait_n(6);
        chk("rev_miso", 32'(r), 32'h8D);
        chk("rev_rx_data", 32'(bus.rx_data), 32'hB1);
        chk("rev_valid_count", 32'(vcount), 32'h1);
        chk("rev_frame_cnt", 32'(bus.frame_cnt), 32'h1);

        // Fresh start so the back-to-back pair leaves frame_cnt = 2
        rst = 1'b1;
        wait_n(3);
        rst = 1'b0;
        wait_n(3);
        chk("rst2_frame_cnt", 32'(bus.frame_cnt), 32'h0);
        v0 = vcount;
        bus.ss = 1'b0;
        wait_n(6);
        frame(2'd1, 8'h3C, r);
        chk("b2b_echo_miso", 32'(r), 32'h3C);
        frame(2'd2, 8'h0F, r);
        chk("b2b_inv_miso", 32'(r), 32'hF0);
        wait_n(6);
        bus.ss = 1'b1;
        wait_n(6);
        chk("b2b_valid_count", 32'(vcount - v0), 32'h2);
        chk("b2b_frame_cnt", 32'(bus.frame_cnt), 32'h2);
        chk("b2b_rx_data", 32'(bus.rx_data), 32'h0F);

        // CNT returns the pre-increment count
        bus.ss = 1'b0;
        wait_n(6);
        frame(2'd3, 8'h00, r);
        wait_n(6);
        bus.ss = 1'b1;
        wait_n(6);
        chk("cnt_miso", 32'(r), 32'h02);
        chk("cnt_frame_cnt", 32'(bus.frame_cnt), 32'h3);

        // Abort after 5 bits of 0xA5
        v0 = vcount;
        bus.ss = 1'b0;
        wait_n(6);
        xbit(1'b1, m);
        xbit(1'b0, m);
        xbit(1'b1, m);
        xbit(1'b0, m);
        xbit(1'b0, m);
        wait_n(6);
        bus.ss = 1'b1;
        wait_n(10);
        chk("abort_valid_count", 32'(vcount - v0), 32'h0);
        chk("abort_rx_data", 32'(bus.rx_data), 32'h00);
        chk("abort_frame_cnt", 32'(bus.frame_cnt), 32'h3);
        chk("abort_miso", 32'(bus.miso), 32'h1);

        bus.ss = 1'b0;
        wait_n(6);
        frame(2'd0, 8'h01, r);
        wait_n(6);
        bus.ss = 1'b1;
        wait_n(6);
        chk("recover_miso", 32'(r), 32'h80);
        chk("recover_rx_data", 32'(bus.rx_data), 32'h01);
        chk("recover_frame_cnt", 32'(bus.frame_cnt), 32'h4);

        // Reset during TX bit 3 of REV 0x55 (reply 0xAA, bit 3 is 0)
        bus.ss = 1'b0;
        wait_n(6);
        bus.op = 2'd0;
        for (int i = 0; i < 8; i++) xbit(i[0] ? 1'b1 : 1'b0, m);
        for (int i = 0; i < 3; i++) xbit(1'b0, m);
        bus.mosi = 1'b0;
        bus.sck  = 1'b1;
        wait_n(3);
        chk("pre_reset_tx_bit3", 32'(bus.miso), 32'h0);
        rst = 1'b1;
        wait_n(1);
        chk("midreset_miso", 32'(bus.miso), 32'h1);
        bus.ss  = 1'b1;
        bus.sck = 1'b0;
        wait_n(3);
        rst = 1'b0;
        wait_n(6);
        chk("midreset_rx_valid", 32'(bus.rx_valid), 32'h0);
        chk("midreset_rx_data", 32'(bus.rx_data), 32'h0);
        chk("midreset_frame_cnt", 32'(bus.frame_cnt), 32'h0);

        bus.ss = 1'b0;
        wait_n(6);
        frame(2'd0, 8'hF0, r);
        wait_n(6);
        bus.ss = 1'b1;
        wait_n(6);
        chk("post_reset_miso", 32'(r), 32'h0F);
        chk("post_reset_rx_data", 32'(bus.rx_data), 32'hF0);
        chk("post_reset_frame_cnt", 32'(bus.frame_cnt), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_xform_slave.md
# spi_xform_slave

Parametrised SPI slave test peripheral for the SoC SPI controller bench, successor to the fixed 8-bit bit-reversal slave. Receives a WIDTH-bit word MSB-first, then returns a transformed word in the same ss-low window. The transform is selectable: reverse, echo, invert, or frame count. Unlike its predecessor it is fully synchronous to the system clock. It also adds frame-abort on ss deassertion, back-to-back frames, and a receive-side status strobe.

## Interface
- WIDTH, 8, frame word width in bits (>= 2).
- SAMPLE_EDGE, 0, active sck edge: 0 = falling (legacy behaviour), 1 = rising.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock from master (asynchronous).
- ss  in  1  slave select, active low (asynchronous).
- mosi  in  1  master data out (asynchronous).
- miso  out  1  slave data out; registered; idles 1.
- op  in  2  transform select: 0 REV, 1 ECHO, 2 INV, 3 CNT; sampled at the receive-complete edge.
- rx_data  out  WIDTH  last fully received word; holds until the next completed receive.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- frame_cnt  out  WIDTH  count of completed receives; wraps at 2^WIDTH.

## Operation
- Input synchronisers:
  - sck, ss and mosi each pass through a 2-flop synchroniser (sck_s, ss_s, mosi_s).
  - A third flop sck_d holds the previous sck_s.
  - An active edge is detected when sck_s != sck_d and sck_s matches SAMPLE_EDGE (1 for rising, 0 for falling).
- State: phase ∈ {RX, TX}; bit counter cnt (log2(WIDTH)+1 bits); rx_sr, tx_sr (WIDTH each).
- While ss_s = 1, every cycle: phase := RX, cnt := 0, miso := 1. rx_sr/tx_sr contents are don't-care. No rx_valid is generated.
- RX phase, active edge with ss_s = 0: rx_sr := {rx_sr[WIDTH-2:0], mosi_s}; cnt := cnt+1.
- When cnt = WIDTH-1 at an active edge (the WIDTH-th bit):
  - rx_data := new word; rx_valid = 1 the following cycle.
  - frame_cnt += 1.
  - tx_sr := result(op, word); phase := TX, cnt := 0.
- Results:
  - REV: bit-reversed word, i.e. word[0] is emitted first.
  - ECHO: word.
  - INV: ~word.
  - CNT: frame_cnt value before this increment.
- TX phase, active edge: tx_sr := {tx_sr[WIDTH-2:0], 1'b0}; cnt := cnt+1.
- When cnt = WIDTH-1 at a TX active edge: phase := RX, cnt := 0. The next frame begins without requiring ss to toggle.
- miso register: next value = (ss_s = 0 and phase = TX) ? tx_sr[WIDTH-1] : 1. The master samples miso on the non-active sck edge.
- Abort: ss_s rising in either phase discards the partial word. rx_data, rx_valid and frame_cnt are unaffected.
- mosi is ignored during TX.
- ss_s = 1 and an active edge in the same cycle: the abort rule wins.
- Reset: phase RX, cnt 0, rx_sr/tx_sr 0, rx_data 0, rx_valid 0, frame_cnt 0, miso 1. Synchroniser flops reset to ss = 1, sck = SAMPLE_EDGE ? 1 : 0 (no spurious edge), mosi = 0.
- Reset asserted mid-frame: miso is 1 from the cycle after the reset edge; the next frame starts clean.

## Timing
- Pin-to-state latency: an sck pin change is registered by flop1 at clock edge k. State updates at edge k+2, and miso updates at edge k+3.
- ss deassertion forces miso = 1 by edge k+3, using the same path.
- rx_valid is high exactly one cycle: the cycle after the state update that completes the receive.
- sck high and low times must each be >= 4 clock periods.
- mosi must be stable from 1 clock before to 3 clocks after the active sck edge.
- The first TX bit is valid on miso 3 clocks after the WIDTH-th active edge, i.e. before the next non-active edge given the minimum half-period.
- Frame length: 2×WIDTH active edges.

## Test plan (WIDTH=8, SAMPLE_EDGE=0)
- Reset, then hold ss high with sck toggling → miso = 1, rx_valid never asserted, frame_cnt = 0.
- op=REV, send 0xB1 → rx_valid pulse, rx_data = 0xB1, miso bits in order 1,0,0,0,1,1,0,1 (0x8D), frame_cnt = 1.
- Back-to-back frames under one ss-low window:
  - ECHO 0x3C → miso 0x3C.
  - INV 0x0F → miso 0xF0.
  - Two rx_valid pulses; frame_cnt = 2.
- After 2 completed frames, op=CNT, send 0x00 → miso 0x02, frame_cnt = 3.
- Abort, then recover:
  - Raise ss after 5 bits of 0xA5 → no rx_valid, rx_data and frame_cnt unchanged.
  - Next full frame REV 0x01 → miso 0x80.
- Assert reset during TX bit 3 → miso = 1 the next cycle, all outputs at reset values; a following frame REV 0xF0 → miso 0x0F.
